input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//   Cleans the raw I and S inputs before they reach the Moore control FSM.
//   Each channel has a 2-FF synchronizer, a debounce counter and a rising-edge detector.
//   The control block consumes the debounced levels outputI/outputS in place of raw pins.
//   Both channels are identical and fully independent; they share only clock and reset.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive cycles the synced input must differ from the stable level before it is accepted; legal range >= 1
//   RESET_LEVEL      0  value loaded into the sync regs, stable levels and level outputs on reset
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width; derived, do not override
// PORTS
//   inputClk      in   1  single system clock; all state updates on posedge
//   inputReset    in   1  synchronous reset, active-high
//   inputI        in   1  raw, asynchronous I level
//   inputS        in   1  raw, asynchronous S level
//   outputI       out  1  debounced I level, to the control FSM input I
//   outputS       out  1  debounced S level, to the control FSM input S
//   outputIRise   out  1  one-cycle pulse on each accepted 0->1 transition of outputI
//   outputSRise   out  1  one-cycle pulse on each accepted 0->1 transition of outputS
// BEHAVIOUR
//   Reset:
//   - inputReset is sampled at posedge. While it is high: sync regs s1/s2 and stable <= RESET_LEVEL; counter <= 0; rise <= 0.
//   - outputI/outputS = RESET_LEVEL; outputIRise/outputSRise = 0.
//   - Reset mid-debounce discards the partial count. Reset always wins over every other event.
//   Per channel, each posedge (not in reset):
//   - s1 <= raw; s2 <= s1.
//   - If s2 == stable: cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2; cnt <= 0; rise <= s2.
//   - Else: cnt <= cnt+1.
//   - rise is 0 on every cycle that does not take the accept branch, so each pulse is exactly 1 cycle wide.
//   Latency:
//   - A raw level first sampled at edge k and held appears on the level output after edge k+1+DEBOUNCE_CYCLES (k+5 at the default).
//   - The rise pulse is high during the same cycle in which the level output first reads 1.
//   Glitch rejection:
//   - Any s2 excursion shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged and returns cnt to 0.
//   - A pulse of exactly DEBOUNCE_CYCLES synced cycles is accepted.
//   Other rules:
//   - Falling transitions update the level output with the same latency and produce no pulse.
//   - DEBOUNCE_CYCLES == 1: stable follows s2 one cycle late; the counter never leaves 0.
//   - The counter never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.
//   - Channels I and S may both accept on the same edge; both pulses then assert together.
//   - No handshake. Outputs are registered, glitch-free and drive the control FSM directly.
// TESTING
//   1. Hold inputReset=1 for 3 cycles with inputI=inputS=1.
//      -> outputI=outputS=0 and no pulses throughout; after release, outputI rises at edge k+5 and outputIRise is high for exactly 1 cycle.
//   2. DEBOUNCE_CYCLES=4: drive inputI 0->1 at edge 10 and hold.
//      -> outputI=1 after edge 15; outputIRise=1 only in the cycle after edge 15.
//   3. inputI high for 3 cycles, then low.
//      -> outputI stays 0 and no pulse; a 4-cycle high pulse is accepted with one outputIRise.
//   4. Toggle inputS 1->0 after it is stable at 1.
//      -> outputS falls 5 edges later; outputSRise stays 0.
//   5. Raise inputI and inputS on the same edge.
//      -> both outputs and both rise pulses change on the same cycle.
//   6. Assert inputReset for 1 cycle 2 cycles into a debounce.
//      -> count discarded; acceptance occurs 5 edges after reset release, not earlier.

Source files
------------

// File: rtl/input_conditioner_if.sv
// ----------------------------------------------------------------------------
// input_conditioner_if
//   Groups the raw inputs and the conditioned outputs of input_conditioner.
//   Clock and reset are not carried here; they stay plain ports on the block.
//
//   Signals
//     inputI       raw, asynchronous I level
//     inputS       raw, asynchronous S level
//     outputI      debounced I level
//     outputS      debounced S level
//     outputIRise  one-cycle pulse on each accepted 0->1 transition of outputI
//     outputSRise  one-cycle pulse on each accepted 0->1 transition of outputS
//
//   Modports
//     master  the side that drives the raw pins and consumes the clean levels
//     slave   the conditioner itself
//
//   There is no valid/ready handshake on this interface: the raw inputs are
//   free-running levels, and every output is a registered level or pulse that
//   is valid on every cycle.
// ----------------------------------------------------------------------------
interface input_conditioner_if;
    logic inputI;
    logic inputS;
    logic outputI;
    logic outputS;
    logic outputIRise;
    logic outputSRise;

    modport master (
        output inputI,
        output inputS,
        input  outputI,
        input  outputS,
        input  outputIRise,
        input  outputSRise
    );

    modport slave (
        input  inputI,
        input  inputS,
        output outputI,
        output outputS,
        output outputIRise,
        output outputSRise
    );
endinterface

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
//   Cleans the raw I and S inputs before they reach the control FSM. Each
//   channel has a 2-FF synchronizer, a debounce counter and a rising-edge
//   detector. The two channels are identical and independent; they share
//   only clock and reset.
//
//   Ports
//     inputClk    single system clock, all state updates on posedge
//     inputReset  synchronous reset, active-high
//     cond_if     input_conditioner_if.slave: raw inputI/inputS in,
//                 outputI/outputS levels and outputIRise/outputSRise out
//
//   Parameters
//     DEBOUNCE_CYCLES  consecutive cycles the synced input must differ from
//                      the stable level before it is accepted (>= 1)
//     RESET_LEVEL      value of the sync regs, stable levels and level
//                      outputs while in reset
//
//   A level held on the raw pin from edge k shows on the level output after
//   edge k+1+DEBOUNCE_CYCLES; the rise pulse is high in that same cycle.
// ----------------------------------------------------------------------------
module input_conditioner #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                inputClk,
    input  logic                inputReset,
    input_conditioner_if.slave  cond_if
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    // Channel 0 is I, channel 1 is S.
    logic [1:0] raw_w;
    logic [1:0] level_w;
    logic [1:0] rise_w;

    assign raw_w = {cond_if.inputS, cond_if.inputI};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             s1_q, s1_d;
        logic             s2_q, s2_d;
        logic             stable_q, stable_d;
        logic             rise_q, rise_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // The counter only runs while s2 disagrees with the stable level, so
        // any excursion shorter than DEBOUNCE_CYCLES drops it back to zero
        // and the counter can never pass CNT_MAX.
        always_comb begin
            s1_d     = raw_w[ch];
            s2_d     = s1_q;
            stable_d = stable_q;
            cnt_d    = '0;
            rise_d   = 1'b0;
            if (s2_q != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_d = s2_q;
                    // Accepting a 1 is necessarily a 0->1 change of stable.
                    rise_d   = s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge inputClk) begin
            if (inputReset) begin
                s1_q     <= RESET_LEVEL;
                s2_q     <= RESET_LEVEL;
                stable_q <= RESET_LEVEL;
                cnt_q    <= '0;
                rise_q   <= 1'b0;
            end else begin
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                rise_q   <= rise_d;
            end
        end

        assign level_w[ch] = stable_q;
        assign rise_w[ch]  = rise_q;
    end

    assign cond_if.outputI     = level_w[0];
    assign cond_if.outputS     = level_w[1];
    assign cond_if.outputIRise = rise_w[0];
    assign cond_if.outputSRise = rise_w[1];

endmodule
